pc_unit: RTL

Parametrised fetch-address generator feeding the instruction fetch stage. It extends the basic increment/branch program counter with several additions: a configurable width, reset vector and step; a fetch-ready stall; a trap redirect with priority; and a circular return address stack (RAS) that predicts return targets. It sits between the branch/trap logic and the instruction memory port.

---
 rtl/pc_unit.sv | 97 +++++++++
 1 files changed

// File: rtl/pc_unit.sv
// pc_unit: fetch-address generator with stall, trap redirect,
// branch override and a circular return address stack.
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              STEP         = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            call,
    input  logic            ret,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    output logic            ras_empty,
    output logic            ras_full
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [XLEN-1:0] STEP_V  = XLEN'(STEP);
    localparam logic [CW-1:0]   DEPTH_V = CW'(RAS_DEPTH);

    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   top;
    logic [CW-1:0]   count;

    logic            accept;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] ras_top;
    logic [XLEN-1:0] next_pc;
    logic            has_entry;
    logic            ras_upd;
    logic            do_push;
    logic            do_swap;
    logic            do_pop;
    logic [PW-1:0]   wr_idx;

    assign accept    = pc_valid & fetch_ready;
    assign seq_pc    = pc_out + STEP_V;
    assign ras_top   = ras_mem[top];
    assign ras_empty = (count == '0);
    assign ras_full  = (count == DEPTH_V);
    assign has_entry = ~ras_empty;

    // A redirect squashes the instruction at pc_out, so it must not
    // touch the stack even though it was accepted.
    assign ras_upd = accept & ~redirect_valid;
    assign do_swap = ras_upd & call & ret & has_entry;
    assign do_push = ras_upd & call & ~(ret & has_entry);
    assign do_pop  = ras_upd & ~call & ret & has_entry;
    assign wr_idx  = do_push ? top + 1'b1 : top;

    always_comb begin
        next_pc = pc_out;
        if (redirect_valid)
            next_pc = redirect_addr;
        else if (branch_taken)
            next_pc = branch_target;
        else if (accept && ret && has_entry)
            next_pc = ras_top;
        else if (accept)
            next_pc = seq_pc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_out   <= RESET_VECTOR;
            pc_valid <= 1'b0;
            top      <= '0;
            count    <= '0;
        end else begin
            pc_out   <= next_pc;
            pc_valid <= ~redirect_valid;
            if (do_push) begin
                top <= top + 1'b1;
                if (!ras_full)
                    count <= count + 1'b1;
            end else if (do_pop) begin
                top   <= top - 1'b1;
                count <= count - 1'b1;
            end
        end
    end

    // Stack contents need no reset; count alone says what is live.
    always_ff @(posedge clk) begin
        if (rst_n && (do_push || do_swap))
            ras_mem[wr_idx] <= seq_pc;
    end

endmodule
